aes_iter_engine: RTL and testbench

//   Iterative AES engine (one round per clock) for AES-128/192/256, selected by NK at elaboration.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_iter_engine_if.sv | 23 ++
 rtl/aes_round.sv | 41 ++++
 rtl/aes_iter_engine.sv | 139 +++++++++++++
 tb/tb_aes_iter_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers: S-box / inverse S-box derived from the field inverse,
// MixColumns in both directions, and the engine FSM encoding.
package aes_pkg;

    localparam int unsigned NB    = 4;
    localparam int unsigned BLK_W = 32 * NB;

    typedef logic [BLK_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } aes_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; columns are 4 consecutive bytes.
    function automatic aes_state_t mix_columns(input aes_state_t s, input logic inv);
        logic [15:0][7:0] a;
        logic [15:0][7:0] m;
        logic [3:0][7:0]  k;
        logic [7:0]       acc;
        a   = s;
        m   = '0;
        acc = '0;
        k   = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(a[4'(15 - (4 * c + (r + j) % 4))], k[2'(3 - j)]);
                end
                m[4'(15 - (4 * c + r))] = acc;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/aes_iter_engine_if.sv
// Block streaming interface of the AES engine: input and output valid/ready channels.
interface aes_iter_engine_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;

    modport master (
        output in_valid, in_data, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_decrypt, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round.sv
// One combinational AES round, forward or inverse; MixColumns is skipped on the last round.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       decrypt,
    input  logic       last_round,
    output aes_state_t result_c
);

    aes_state_t sub_shift;
    aes_state_t pre_mix;
    aes_state_t mixed;
    aes_state_t post_mix;

    // (Inv)SubBytes and (Inv)ShiftRows commute, so both are one byte gather.
    always_comb begin
        logic [15:0][7:0] src;
        logic [15:0][7:0] dst;
        src = state;
        dst = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (decrypt) begin
                    dst[4'(15 - (r + 4 * c))] = inv_sbox(src[4'(15 - (r + 4 * ((c + 4 - r) % 4)))]);
                end else begin
                    dst[4'(15 - (r + 4 * c))] = sbox(src[4'(15 - (r + 4 * ((c + r) % 4)))]);
                end
            end
        end
        sub_shift = dst;
    end

    // The inverse round adds the key before InvMixColumns so the forward key schedule can be used as-is.
    assign pre_mix  = decrypt ? (sub_shift ^ round_key) : sub_shift;
    assign mixed    = mix_columns(pre_mix, decrypt);
    assign post_mix = last_round ? pre_mix : mixed;
    assign result_c = decrypt ? post_mix : (post_mix ^ round_key);

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES-128/192/256 engine, one round per clock, valid/ready in and out.
// Optional counter mode under macro AES_CTR_EN.
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter  int unsigned NK  = 8,
    localparam int unsigned NR  = NK + 6,
    localparam int unsigned RKW = 128 * (NR + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RKW-1:0]   round_keys,
    aes_iter_engine_if.slave io,
    output logic             busy
`ifdef AES_CTR_EN
    ,
    input  logic             ctr_load,
    input  aes_state_t       ctr_init,
    output aes_state_t       ctr_value
`endif
);

    localparam int unsigned RND_W = $clog2(NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
        $error("aes_iter_engine: NK must be 4, 6 or 8");
    end

    aes_fsm_t         fsm_q;
    logic [RND_W-1:0] rnd_q;
    aes_state_t       state_q;
    logic             dec_q;
    logic             out_valid_q;
    aes_state_t       out_data_q;

    aes_state_t       rk [NR+1];
    logic [RND_W-1:0] key_idx;
    aes_state_t       rk_sel;
    logic             last_round;
    aes_state_t       round_c;
    aes_state_t       blk_src;
    logic             dec_in;
    aes_state_t       result_c;
    logic             accept;

    for (genvar i = 0; i <= NR; i++) begin : g_rk
        assign rk[i] = round_keys[RKW-1-128*i -: 128];
    end

    assign key_idx    = dec_q ? (RND_W'(NR) - rnd_q) : rnd_q;
    assign rk_sel     = rk[key_idx];
    assign last_round = (rnd_q == RND_W'(NR));

    aes_round u_round (
        .state      (state_q),
        .round_key  (rk_sel),
        .decrypt    (dec_q),
        .last_round (last_round),
        .result_c   (round_c)
    );

`ifdef AES_CTR_EN
    aes_state_t ctr_q;
    aes_state_t data_q;

    // Counter mode always runs the forward cipher on the counter, then masks the latched block.
    assign blk_src     = ctr_q;
    assign dec_in      = 1'b0;
    assign result_c    = round_c ^ data_q;
    assign io.in_ready = (fsm_q == S_IDLE) && !reset && !ctr_load;
    assign ctr_value   = ctr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q  <= '0;
            data_q <= '0;
        end else begin
            if (fsm_q == S_IDLE && ctr_load) begin
                ctr_q <= ctr_init;
            end else if (fsm_q == S_DONE && io.out_ready) begin
                ctr_q <= ctr_q + 128'd1;
            end
            if (accept) data_q <= io.in_data;
        end
    end
`else
    assign blk_src     = io.in_data;
    assign dec_in      = io.in_decrypt;
    assign result_c    = round_c;
    assign io.in_ready = (fsm_q == S_IDLE) && !reset;
`endif

    assign accept       = io.in_valid && io.in_ready;
    assign busy         = (fsm_q != S_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

    // Control FSM: whitening on accept, one round per edge, hold result until the sink takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= blk_src ^ (dec_in ? rk[NR] : rk[0]);
                        dec_q   <= dec_in;
                        rnd_q   <= RND_W'(1);
                        fsm_q   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= round_c;
                    if (last_round) begin
                        fsm_q       <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= result_c;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        fsm_q       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        rnd_q       <= '0;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_engine.sv
// Directed bench for aes_iter_engine with NK=4/6/8 instances and FIPS-197 vectors.
// Build with AES_CTR_EN defined to exercise counter mode instead of plain encrypt/decrypt.
module tb_aes_iter_engine;
    import aes_pkg::*;

    localparam aes_state_t PT  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_state_t CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_state_t CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam aes_state_t CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic reset;
    logic [1407:0] rk4;
    logic [1663:0] rk6;
    logic [1919:0] rk8;

    logic       drv_valid [3];
    aes_state_t drv_data  [3];
    logic       drv_dec   [3];
    logic       drv_ordy  [3];
    logic       mon_irdy  [3];
    logic       mon_ovalid[3];
    aes_state_t mon_odata [3];
    logic       mon_busy  [3];
`ifdef AES_CTR_EN
    logic       ctr_load  [3];
    aes_state_t ctr_init  [3];
    aes_state_t ctr_value [3];
`endif

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    aes_iter_engine_if if4 ();
    aes_iter_engine_if if6 ();
    aes_iter_engine_if if8 ();

    aes_iter_engine #(.NK(4)) u_aes4 (
        .clk(clk), .reset(reset), .round_keys(rk4), .io(if4), .busy(mon_busy[0])
`ifdef AES_CTR_EN
        , .ctr_load(ctr_load[0]), .ctr_init(ctr_init[0]), .ctr_value(ctr_value[0])
`endif
    );
    aes_iter_engine #(.NK(6)) u_aes6 (
        .clk(clk), .reset(reset), .round_keys(rk6), .io(if6), .busy(mon_busy[1])
`ifdef AES_CTR_EN
        , .ctr_load(ctr_load[1]), .ctr_init(ctr_init[1]), .ctr_value(ctr_value[1])
`endif
    );
    aes_iter_engine #(.NK(8)) u_aes8 (
        .clk(clk), .reset(reset), .round_keys(rk8), .io(if8), .busy(mon_busy[2])
`ifdef AES_CTR_EN
        , .ctr_load(ctr_load[2]), .ctr_init(ctr_init[2]), .ctr_value(ctr_value[2])
`endif
    );

    assign if4.in_valid   = drv_valid[0];
    assign if4.in_data    = drv_data[0];
    assign if4.in_decrypt = drv_dec[0];
    assign if4.out_ready  = drv_ordy[0];
    assign if6.in_valid   = drv_valid[1];
    assign if6.in_data    = drv_data[1];
    assign if6.in_decrypt = drv_dec[1];
    assign if6.out_ready  = drv_ordy[1];
    assign if8.in_valid   = drv_valid[2];
    assign if8.in_data    = drv_data[2];
    assign if8.in_decrypt = drv_dec[2];
    assign if8.out_ready  = drv_ordy[2];
    assign mon_irdy[0]    = if4.in_ready;
    assign mon_ovalid[0]  = if4.out_valid;
    assign mon_odata[0]   = if4.out_data;
    assign mon_irdy[1]    = if6.in_ready;
    assign mon_ovalid[1]  = if6.out_valid;
    assign mon_odata[1]   = if6.out_data;
    assign mon_irdy[2]    = if8.in_ready;
    assign mon_ovalid[2]  = if8.out_valid;
    assign mon_odata[2]   = if8.out_data;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // FIPS-197 key expansion; word 0 ends up in the MSBs of the used low part.
    function automatic logic [1919:0] expand_key(input int nk);
        logic [31:0]   w [64];
        logic [255:0]  key;
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] flat;
        key  = KEY256;
        rcon = 8'h01;
        flat = '0;
        for (int i = 0; i < 64; i++) w[6'(i)] = '0;
        for (int i = 0; i < nk; i++) begin
            w[6'(i)] = key[255:224];
            key = key << 32;
        end
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[6'(i - 1)];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[6'(i)] = w[6'(i - nk)] ^ t;
        end
        for (int i = 0; i < 4 * (nk + 7); i++) flat = {flat[1887:0], w[6'(i)]};
        return flat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, wait for the result and check data and first-valid cycle.
    task automatic run_block(input logic [1:0] k, input aes_state_t data, input logic dec,
                             input aes_state_t exp, input int lat, input string tag);
        int cyc;
        drv_valid[k] = 1'b1;
        drv_data[k]  = data;
        drv_dec[k]   = dec;
        cyc = 0;
        while (!mon_irdy[k] && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (mon_irdy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b want 1", tag, mon_irdy[k]);
        end
        tick();
        drv_valid[k] = 1'b0;
        cyc = 1;
        while (!mon_ovalid[k] && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== lat) begin
            n_err++;
            $display("FAIL %s latency: out_valid in cycle %0d want %0d", tag, cyc, lat);
        end
        n_vec++;
        if (mon_odata[k] !== exp) begin
            n_err++;
            $display("FAIL %s data: got %h want %h", tag, mon_odata[k], exp);
        end
        if (drv_ordy[k]) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({mon_irdy[2'(i)], mon_ovalid[2'(i)], mon_busy[2'(i)]} !== 3'b000 ||
                mon_odata[2'(i)] !== '0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: rdy/vld/busy=%b%b%b data=%h want 000 and 0", i,
                         mon_irdy[2'(i)], mon_ovalid[2'(i)], mon_busy[2'(i)], mon_odata[2'(i)]);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (mon_irdy[2'(i)] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_release[%0d]: in_ready=%b want 1", i, mon_irdy[2'(i)]);
            end
        end
    endtask

`ifdef AES_CTR_EN
    task automatic test_ctr();
        int cyc;
        ctr_load[0]  = 1'b1;
        ctr_init[0]  = PT;
        drv_valid[0] = 1'b1;
        drv_data[0]  = '0;
        #1;
        n_vec++;
        if (mon_irdy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ctr_priority: in_ready=%b want 0", mon_irdy[0]);
        end
        tick();
        ctr_load[0] = 1'b0;
        n_vec++;
        if (ctr_value[0] !== PT || mon_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ctr_load: ctr=%h busy=%b want %h busy 0", ctr_value[0], mon_busy[0], PT);
        end
        run_block(2'd0, '0, 1'b0, CT4, 11, "ctr_enc");
        n_vec++;
        if (ctr_value[0] !== 128'h00112233445566778899aabbccddef00) begin
            n_err++;
            $display("FAIL ctr_incr: ctr=%h want 00112233445566778899aabbccddef00", ctr_value[0]);
        end
        ctr_load[0] = 1'b1;
        ctr_init[0] = '1;
        tick();
        ctr_load[0]  = 1'b0;
        drv_valid[0] = 1'b1;
        tick();
        drv_valid[0] = 1'b0;
        cyc = 1;
        while (!mon_ovalid[0] && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 11) begin
            n_err++;
            $display("FAIL ctr_wrap latency: cycle %0d want 11", cyc);
        end
        tick();
        n_vec++;
        if (ctr_value[0] !== '0) begin
            n_err++;
            $display("FAIL ctr_wrap: ctr=%h want 0", ctr_value[0]);
        end
    endtask
`else
    task automatic test_encrypt();
        run_block(2'd0, PT, 1'b0, CT4, 11, "enc128");
        n_vec++;
        if (mon_ovalid[0] !== 1'b0 || mon_odata[0] !== CT4 || mon_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL enc128_after: vld=%b busy=%b data=%h want 0 0 %h",
                     mon_ovalid[0], mon_busy[0], mon_odata[0], CT4);
        end
        run_block(2'd1, PT, 1'b0, CT6, 13, "enc192");
        run_block(2'd2, PT, 1'b0, CT8, 15, "enc256");
    endtask

    task automatic test_decrypt();
        run_block(2'd0, CT4, 1'b1, PT, 11, "dec128");
        run_block(2'd1, CT6, 1'b1, PT, 13, "dec192");
        run_block(2'd2, CT8, 1'b1, PT, 15, "dec256");
    endtask

    task automatic test_back_to_back();
        aes_state_t vin [4];
        aes_state_t vexp[4];
        logic       vdec[4];
        int         acc [4];
        int         idx;
        int         got;
        logic       hs_in;
        vin[0] = PT;  vdec[0] = 1'b0; vexp[0] = CT4;
        vin[1] = CT4; vdec[1] = 1'b1; vexp[1] = PT;
        vin[2] = PT;  vdec[2] = 1'b0; vexp[2] = CT4;
        vin[3] = CT4; vdec[3] = 1'b1; vexp[3] = PT;
        for (int i = 0; i < 4; i++) acc[2'(i)] = 0;
        idx = 0;
        got = 0;
        drv_valid[0] = 1'b1;
        drv_data[0]  = vin[0];
        drv_dec[0]   = vdec[0];
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            hs_in = mon_irdy[0] && drv_valid[0];
            if (mon_ovalid[0] && drv_ordy[0]) begin
                n_vec++;
                if (mon_odata[0] !== vexp[2'(got)]) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", got, mon_odata[0], vexp[2'(got)]);
                end
                got++;
            end
            tick();
            if (hs_in) begin
                acc[2'(idx)] = cyc;
                idx++;
                if (idx < 4) begin
                    drv_data[0] = vin[2'(idx)];
                    drv_dec[0]  = vdec[2'(idx)];
                end else begin
                    drv_valid[0] = 1'b0;
                end
            end
        end
        drv_valid[0] = 1'b0;
        n_vec++;
        if (got !== 4) begin
            n_err++;
            $display("FAIL b2b_count: results %0d want 4", got);
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if (acc[2'(i)] - acc[2'(i - 1)] !== 12) begin
                n_err++;
                $display("FAIL b2b_period[%0d]: %0d cycles want 12", i, acc[2'(i)] - acc[2'(i - 1)]);
            end
        end
    endtask

    task automatic test_stall();
        drv_ordy[0] = 1'b0;
        run_block(2'd0, PT, 1'b0, CT4, 11, "stall_enc");
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (mon_odata[0] !== CT4 || mon_ovalid[0] !== 1'b1 || mon_irdy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: data=%h vld=%b rdy=%b want %h 1 0",
                         i, mon_odata[0], mon_ovalid[0], mon_irdy[0], CT4);
            end
        end
        drv_ordy[0] = 1'b1;
        tick();
        n_vec++;
        if (mon_irdy[0] !== 1'b1 || mon_ovalid[0] !== 1'b0 || mon_odata[0] !== CT4) begin
            n_err++;
            $display("FAIL stall_release: rdy=%b vld=%b data=%h want 1 0 %h",
                     mon_irdy[0], mon_ovalid[0], mon_odata[0], CT4);
        end
        run_block(2'd0, CT4, 1'b1, PT, 11, "stall_next");
    endtask

    task automatic test_reset_mid();
        drv_valid[0] = 1'b1;
        drv_data[0]  = PT;
        drv_dec[0]   = 1'b0;
        tick();
        drv_valid[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        n_vec++;
        if ({mon_ovalid[0], mon_busy[0], mon_irdy[0]} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: vld/busy/rdy=%b%b%b want 000", mon_ovalid[0], mon_busy[0], mon_irdy[0]);
        end
        tick();
        n_vec++;
        if ({mon_ovalid[0], mon_busy[0], mon_irdy[0]} !== 3'b000 || mon_odata[0] !== '0) begin
            n_err++;
            $display("FAIL reset_mid_hold: vld/busy/rdy=%b%b%b data=%h want 000 0",
                     mon_ovalid[0], mon_busy[0], mon_irdy[0], mon_odata[0]);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (mon_irdy[0] !== 1'b1 || mon_ovalid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release: rdy=%b vld=%b want 1 0", mon_irdy[0], mon_ovalid[0]);
        end
        run_block(2'd0, PT, 1'b0, CT4, 11, "reset_fresh");
    endtask
`endif

    initial begin
        logic [1919:0] flat;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_valid[2'(i)] = 1'b0;
            drv_data[2'(i)]  = '0;
            drv_dec[2'(i)]   = 1'b0;
            drv_ordy[2'(i)]  = 1'b1;
`ifdef AES_CTR_EN
            ctr_load[2'(i)]  = 1'b0;
            ctr_init[2'(i)]  = '0;
`endif
        end
        flat = expand_key(4);
        rk4  = flat[1407:0];
        flat = expand_key(6);
        rk6  = flat[1663:0];
        rk8  = expand_key(8);

        test_reset();
`ifdef AES_CTR_EN
        test_ctr();
`else
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
